fp32_mul_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one pipelined fp32 multiplier (the `fp32Multiplier` datapath) among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes, issues at most one operation per cycle into the multiplier, and tracks the requester ID of every in-flight operation in a tag FIFO. When the multiplier reports completion, the block routes the result and exception flags back to the originating requester. It sits between the requester-side compute units and the multiplier instance.

---
 rtl/fp32_mul_arbiter_if.sv | 53 +++++
 rtl/fp32_mul_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fp32_mul_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp32_mul_arbiter_if                                              |
// | Requester and multiplier-side signal bundle of fp32_mul_arbiter. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fp32_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Requester side
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*32-1:0] req_a_i;
  logic [NUM_REQ*32-1:0] req_b_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [31:0]           rsp_data_o;
  logic                  rsp_overflow_o;
  logic                  rsp_underflow_o;
  logic                  rsp_invalid_o;
  // Multiplier side
  logic                  mul_valid_o;
  logic [31:0]           mul_a_o;
  logic [31:0]           mul_b_o;
  logic [31:0]           mul_result_i;
  logic                  mul_done_i;
  logic                  mul_overflow_i;
  logic                  mul_underflow_i;
  logic                  mul_invalid_i;
  // Status
  logic                  busy_o;
  logic                  err_orphan_o;

  // Arbiter view
  modport slave (
    input  req_valid_i, req_a_i, req_b_i,
    input  mul_result_i, mul_done_i, mul_overflow_i, mul_underflow_i, mul_invalid_i,
    output req_ready_o, rsp_valid_o, rsp_data_o,
    output rsp_overflow_o, rsp_underflow_o, rsp_invalid_o,
    output mul_valid_o, mul_a_o, mul_b_o,
    output busy_o, err_orphan_o
  );

  // Environment view (requesters plus multiplier)
  modport master (
    output req_valid_i, req_a_i, req_b_i,
    output mul_result_i, mul_done_i, mul_overflow_i, mul_underflow_i, mul_invalid_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o,
    input  rsp_overflow_o, rsp_underflow_o, rsp_invalid_o,
    input  mul_valid_o, mul_a_o, mul_b_o,
    input  busy_o, err_orphan_o
  );
endinterface
`default_nettype wire

// File: rtl/fp32_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp32_mul_arbiter                                                 |
// | Round-robin scheduler sharing one pipelined fp32 multiplier      |
// | among NUM_REQ requesters; a tag FIFO routes results back.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fp32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  fp32_mul_arbiter_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Round-robin pointer
  logic [ID_W-1:0]    ptr_q, ptr_d;

  // Issue register (one operation between handshake and multiplier)
  logic               iss_vld_q, iss_vld_d;
  logic [31:0]        iss_a_q, iss_a_d;
  logic [31:0]        iss_b_q, iss_b_d;
  logic [ID_W-1:0]    iss_id_q, iss_id_d;

  // Tag FIFO
  logic [ID_W-1:0]    tag_mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Response register
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_unf_q, rsp_unf_d;
  logic               rsp_inv_q, rsp_inv_d;
  logic               err_orphan_q, err_orphan_d;

  // Arbitration wires
  logic [CNT_W:0]     occupancy;
  logic               arb_en;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      scan_idx;
  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  logic               push;
  logic               pop;
  logic               orphan;
  logic [ID_W-1:0]    head_tag;

  // Outstanding work seen by the arbiter includes the op waiting in the issue register
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(iss_vld_q);
  assign arb_en    = occupancy < (CNT_W+1)'(DEPTH);

  // Scan requesters starting at ptr, wrapping at NUM_REQ; first valid one wins
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && bus.req_valid_i[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  assign grant     = (arb_en && win_found) ? (NUM_REQ'(1) << win_id) : '0;
  assign handshake = arb_en && win_found;

  assign push     = iss_vld_q;
  assign pop      = bus.mul_done_i && (count_q != '0);
  assign orphan   = bus.mul_done_i && (count_q == '0);
  assign head_tag = tag_mem_q[rd_ptr_q];

  // Next-state for pointer, issue register, FIFO bookkeeping and responses
  always_comb begin
    ptr_d        = ptr_q;
    iss_vld_d    = handshake;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_id_d     = iss_id_q;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q;
    rsp_vld_d    = '0;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    rsp_inv_d    = rsp_inv_q;
    err_orphan_d = err_orphan_q | orphan;

    if (handshake) begin
      ptr_d    = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
      iss_a_d  = bus.req_a_i[{win_id, 5'b00000} +: 32];
      iss_b_d  = bus.req_b_i[{win_id, 5'b00000} +: 32];
      iss_id_d = win_id;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      rsp_vld_d  = NUM_REQ'(1) << head_tag;
      rsp_data_d = bus.mul_result_i;
      rsp_ovf_d  = bus.mul_overflow_i;
      rsp_unf_d  = bus.mul_underflow_i;
      rsp_inv_d  = bus.mul_invalid_i;
    end
  end

  // State registers with synchronous reset; reset drops all in-flight tags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      iss_vld_q    <= 1'b0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_id_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_vld_q    <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      rsp_inv_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      iss_vld_q    <= iss_vld_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_id_q     <= iss_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
      rsp_inv_q    <= rsp_inv_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage; validity is tracked by the pointers so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= iss_id_q;
    end
  end

  assign bus.req_ready_o     = grant;
  assign bus.rsp_valid_o     = rsp_vld_q;
  assign bus.rsp_data_o      = rsp_data_q;
  assign bus.rsp_overflow_o  = rsp_ovf_q;
  assign bus.rsp_underflow_o = rsp_unf_q;
  assign bus.rsp_invalid_o   = rsp_inv_q;
  assign bus.mul_valid_o     = iss_vld_q;
  assign bus.mul_a_o         = iss_a_q;
  assign bus.mul_b_o         = iss_b_q;
  assign bus.busy_o          = (count_q != '0) || iss_vld_q;
  assign bus.err_orphan_o    = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp32_mul_arbiter                                              |
// | Self-checking bench: queue-based reference model, multiplier     |
// | stand-in with fixed latency, directed and random traffic.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fp32_mul_arbiter;

  localparam int NREQ = 4;
  localparam int DEP  = 8;
  localparam int LAT  = 4;

  typedef struct packed {logic [31:0] r; logic ov; logic un; logic inv;} res_t;
  typedef struct {int id; logic [31:0] a; logic [31:0] b;} op_t;
  typedef struct {int due; logic [31:0] a; logic [31:0] b;} mop_t;
  typedef struct {int cyc; int id;} hs_t;
  typedef struct {int cyc; logic [3:0] vec; logic [31:0] data; logic ov; logic un; logic inv;} rs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp_rst = 1'b1;

  fp32_mul_arbiter_if #(.NUM_REQ(NREQ)) m_if ();
  fp32_mul_arbiter_if #(.NUM_REQ(NREQ)) bp_if ();

  fp32_mul_arbiter #(.NUM_REQ(NREQ), .DEPTH(DEP)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (m_if.slave)
  );

  fp32_mul_arbiter #(.NUM_REQ(NREQ), .DEPTH(2)) u_dut_bp (
    .clk_i (clk),
    .rst_i (bp_rst),
    .bus   (bp_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // stimulus controls
  logic [3:0]  s_valid = '0;
  logic [31:0] s_a [NREQ];
  logic [31:0] s_b [NREQ];
  bit          s_rst = 1'b1;
  bit          hold_done = 1'b0;
  bit          force_done = 1'b0;
  bit          chk_en = 1'b0;

  // reference model state
  int   ptr_m = 0;
  op_t  fifo_m [$];
  bit   iss_vld_m = 1'b0;
  op_t  iss_op_m;
  bit   exp_rsp_vld = 1'b0;
  op_t  exp_rsp_op;
  bit   orphan_m = 1'b0;

  // multiplier stand-in and observation logs
  mop_t emu_q [$];
  hs_t  hs_log [$];
  rs_t  rsp_log [$];
  int   n_hs = 0;
  int   n_rsp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Truncating fp32 multiply with flush-to-zero; plays the multiplier's role
  function automatic res_t fmul(input logic [31:0] a, input logic [31:0] b);
    res_t        o;
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    o  = '0;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
      o.r = 32'h7FC00000; o.inv = 1'b1;
    end else if (ea == 255 || eb == 255) begin
      o.r = {s, 8'hFF, 23'h0};
    end else if (ea == 0 || eb == 0) begin
      o.r = {s, 31'h0};
    end else begin
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin e = e + 1; m = p[46:24]; end
      else       m = p[45:23];
      if (e >= 255)    begin o.r = {s, 8'hFF, 23'h0}; o.ov = 1'b1; end
      else if (e <= 0) begin o.r = {s, 31'h0};        o.un = 1'b1; end
      else             o.r = {s, 8'(e), m};
    end
    return o;
  endfunction

  // One clock cycle: drive inputs at negedge, compare, advance the model
  task automatic step();
    bit         done_now;
    res_t       r;
    int         occ, win;
    logic [3:0] exp_ready;
    res_t       er;
    @(negedge clk);
    rst = s_rst;
    m_if.req_valid_i = s_valid;
    for (int k = 0; k < NREQ; k++) begin
      m_if.req_a_i[32*k +: 32] = s_a[k];
      m_if.req_b_i[32*k +: 32] = s_b[k];
    end
    done_now = 1'b0;
    r = '{r: $urandom, ov: 1'b0, un: 1'b0, inv: 1'b0};
    if (force_done) begin
      done_now = 1'b1;
    end else if (!s_rst && !hold_done && emu_q.size() > 0 && emu_q[0].due <= cyc) begin
      r = fmul(emu_q[0].a, emu_q[0].b);
      void'(emu_q.pop_front());
      done_now = 1'b1;
    end
    m_if.mul_done_i      = done_now;
    m_if.mul_result_i    = r.r;
    m_if.mul_overflow_i  = r.ov;
    m_if.mul_underflow_i = r.un;
    m_if.mul_invalid_i   = r.inv;
    #1;

    // expected arbitration decision
    occ = fifo_m.size() + (iss_vld_m ? 1 : 0);
    win = -1;
    if (occ < DEP) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win < 0 && s_valid[(ptr_m + i) % NREQ]) win = (ptr_m + i) % NREQ;
      end
    end
    exp_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;

    if (chk_en) begin
      chk("mul_valid", 64'(m_if.mul_valid_o), 64'(iss_vld_m));
      if (iss_vld_m) begin
        chk("mul_a", 64'(m_if.mul_a_o), 64'(iss_op_m.a));
        chk("mul_b", 64'(m_if.mul_b_o), 64'(iss_op_m.b));
      end
      chk("busy", 64'(m_if.busy_o), 64'((fifo_m.size() != 0) || iss_vld_m));
      chk("err_orphan", 64'(m_if.err_orphan_o), 64'(orphan_m));
      chk("rsp_valid", 64'(m_if.rsp_valid_o), exp_rsp_vld ? 64'(4'b0001 << exp_rsp_op.id) : 64'h0);
      if (exp_rsp_vld) begin
        er = fmul(exp_rsp_op.a, exp_rsp_op.b);
        chk("rsp_data", 64'(m_if.rsp_data_o), 64'(er.r));
        chk("rsp_flags", 64'({m_if.rsp_overflow_o, m_if.rsp_underflow_o, m_if.rsp_invalid_o}),
            64'({er.ov, er.un, er.inv}));
      end
      chk("req_ready", 64'(m_if.req_ready_o), 64'(exp_ready));
    end

    // observation logs
    for (int k = 0; k < NREQ; k++) begin
      if (m_if.req_ready_o[k] && s_valid[k]) begin
        hs_log.push_back('{cyc: cyc, id: k});
        n_hs++;
      end
    end
    if (m_if.rsp_valid_o != 0) begin
      rsp_log.push_back('{cyc: cyc, vec: m_if.rsp_valid_o, data: m_if.rsp_data_o,
                          ov: m_if.rsp_overflow_o, un: m_if.rsp_underflow_o, inv: m_if.rsp_invalid_o});
      n_rsp++;
    end

    // advance model
    if (s_rst) begin
      ptr_m = 0; fifo_m.delete(); iss_vld_m = 1'b0; exp_rsp_vld = 1'b0; orphan_m = 1'b0;
      emu_q.delete();
    end else begin
      if (m_if.mul_valid_o) emu_q.push_back('{due: cyc + LAT, a: m_if.mul_a_o, b: m_if.mul_b_o});
      exp_rsp_vld = 1'b0;
      if (done_now) begin
        if (fifo_m.size() > 0) begin
          exp_rsp_op  = fifo_m.pop_front();
          exp_rsp_vld = 1'b1;
        end else begin
          orphan_m = 1'b1;
        end
      end
      if (iss_vld_m) fifo_m.push_back(iss_op_m);
      iss_vld_m = (win >= 0);
      if (win >= 0) begin
        iss_op_m = '{id: win, a: s_a[win], b: s_b[win]};
        ptr_m    = (win + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    s_valid = '0;
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    hs_log.delete();
    rsp_log.delete();
  endtask

  int hs0, rsp0, budget, bp_hs, bp_pop, hold_cnt;

  initial begin
    for (int k = 0; k < NREQ; k++) begin s_a[k] = '0; s_b[k] = '0; end
    m_if.req_valid_i = '0; m_if.req_a_i = '0; m_if.req_b_i = '0;
    m_if.mul_done_i = 1'b0; m_if.mul_result_i = '0;
    m_if.mul_overflow_i = 1'b0; m_if.mul_underflow_i = 1'b0; m_if.mul_invalid_i = 1'b0;
    bp_if.req_valid_i = '0; bp_if.req_a_i = '0; bp_if.req_b_i = '0;
    bp_if.mul_done_i = 1'b0; bp_if.mul_result_i = 32'h3F800000;
    bp_if.mul_overflow_i = 1'b0; bp_if.mul_underflow_i = 1'b0; bp_if.mul_invalid_i = 1'b0;

    // initial reset; state is unknown until the first reset edge
    s_rst = 1'b1;
    step();
    chk_en = 1'b1;
    do_reset();

    // reset values
    step();
    chk("rst_outputs", 64'({m_if.req_ready_o, m_if.rsp_valid_o, m_if.mul_valid_o, m_if.busy_o, m_if.err_orphan_o}), 64'h0);
    chk("rst_data", 64'({m_if.rsp_data_o, m_if.mul_a_o}), 64'h0);

    // single request from requester 2
    hs_log.delete(); rsp_log.delete();
    s_a[2] = 32'h3F800000; s_b[2] = 32'h40000000; s_valid = 4'b0100;
    step();
    s_valid = '0;
    repeat (10) step();
    chk("single_hs_count", 64'(hs_log.size()), 64'd1);
    chk("single_rsp_count", 64'(rsp_log.size()), 64'd1);
    if (hs_log.size() == 1 && rsp_log.size() == 1) begin
      chk("single_latency", 64'(rsp_log[0].cyc - hs_log[0].cyc), 64'd6);
      chk("single_vec", 64'(rsp_log[0].vec), 64'h4);
      chk("single_data", 64'(rsp_log[0].data), 64'h40000000);
      chk("single_flags", 64'({rsp_log[0].ov, rsp_log[0].un, rsp_log[0].inv}), 64'h0);
    end

    // fairness with all requesters valid
    do_reset();
    for (int k = 0; k < NREQ; k++) begin s_a[k] = 32'h40400000; s_b[k] = 32'h40000000; end
    s_valid = 4'b1111;
    repeat (8) step();
    s_valid = '0;
    repeat (12) step();
    chk("fair_hs_count", 64'(hs_log.size()), 64'd8);
    chk("fair_rsp_count", 64'(rsp_log.size()), 64'd8);
    if (hs_log.size() == 8 && rsp_log.size() == 8) begin
      chk("fair_latency", 64'(rsp_log[0].cyc - hs_log[0].cyc), 64'd6);
      for (int i = 0; i < 8; i++) begin
        chk("fair_grant_id", 64'(hs_log[i].id), 64'(i % 4));
        chk("fair_grant_cyc", 64'(hs_log[i].cyc - hs_log[0].cyc), 64'(i));
        chk("fair_rsp_vec", 64'(rsp_log[i].vec), 64'(4'b0001 << (i % 4)));
        chk("fair_rsp_cyc", 64'(rsp_log[i].cyc - rsp_log[0].cyc), 64'(i));
        chk("fair_rsp_data", 64'(rsp_log[i].data), 64'h40C00000);
      end
    end

    // flag routing
    hs_log.delete(); rsp_log.delete();
    s_a[1] = 32'h7F000000; s_b[1] = 32'h7F000000;
    s_a[3] = 32'h00000000; s_b[3] = 32'h7F800000;
    s_valid = 4'b0010; step();
    s_valid = 4'b1000; step();
    s_valid = '0;
    repeat (10) step();
    chk("flag_rsp_count", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      chk("ovf_vec", 64'(rsp_log[0].vec), 64'h2);
      chk("ovf_data", 64'(rsp_log[0].data), 64'h7F800000);
      chk("ovf_flags", 64'({rsp_log[0].ov, rsp_log[0].un, rsp_log[0].inv}), 64'b100);
      chk("inv_vec", 64'(rsp_log[1].vec), 64'h8);
      chk("inv_data", 64'(rsp_log[1].data), 64'h7FC00000);
      chk("inv_flags", 64'({rsp_log[1].ov, rsp_log[1].un, rsp_log[1].inv}), 64'b001);
    end

    // orphan done with an empty FIFO
    rsp_log.delete();
    force_done = 1'b1; step(); force_done = 1'b0;
    step();
    chk("orphan_set", 64'(m_if.err_orphan_o), 64'd1);
    repeat (3) step();
    chk("orphan_sticky", 64'(m_if.err_orphan_o), 64'd1);
    chk("orphan_no_rsp", 64'(rsp_log.size()), 64'd0);

    // reset with three operations in flight
    for (int k = 0; k < NREQ; k++) begin s_a[k] = 32'h40400000; s_b[k] = 32'h40000000; end
    s_valid = 4'b0111;
    repeat (3) step();
    s_valid = '0;
    step();
    do_reset();
    step();
    chk("midrst_outputs", 64'({m_if.rsp_valid_o, m_if.mul_valid_o, m_if.busy_o, m_if.err_orphan_o}), 64'h0);
    chk("midrst_data", 64'({m_if.rsp_data_o, m_if.mul_b_o}), 64'h0);
    hs_log.delete(); rsp_log.delete();
    s_valid = 4'b1111; step(); s_valid = '0;
    repeat (10) step();
    chk("postrst_hs_count", 64'(hs_log.size()), 64'd1);
    if (hs_log.size() == 1) chk("postrst_ptr0", 64'(hs_log[0].id), 64'd0);
    chk("postrst_rsp_count", 64'(rsp_log.size()), 64'd1);
    if (rsp_log.size() == 1) begin
      chk("postrst_vec", 64'(rsp_log[0].vec), 64'h1);
      chk("postrst_data", 64'(rsp_log[0].data), 64'h40C00000);
    end
    chk("postrst_no_orphan", 64'(m_if.err_orphan_o), 64'd0);

    // random traffic with bursts of withheld completions
    hs0 = n_hs; rsp0 = n_rsp; budget = cyc + 20000; hold_cnt = 0;
    while ((n_hs - hs0) < 2000 && cyc < budget) begin
      s_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < NREQ; k++) begin s_a[k] = $urandom; s_b[k] = $urandom; end
      if (hold_cnt > 0) begin hold_cnt--; hold_done = 1'b1; end
      else if ($urandom_range(0, 39) == 0) begin hold_cnt = $urandom_range(5, 20); hold_done = 1'b1; end
      else hold_done = 1'b0;
      step();
    end
    chk("rand_hs_reached", 64'((n_hs - hs0) >= 2000), 64'd1);
    s_valid = '0; hold_done = 1'b0;
    budget = cyc + 300;
    while ((fifo_m.size() > 0 || iss_vld_m || exp_rsp_vld || m_if.busy_o) && cyc < budget) step();
    step();
    chk("rand_drained", 64'(m_if.busy_o), 64'd0);
    chk("rand_rsp_total", 64'(n_rsp - rsp0), 64'(n_hs - hs0));

    // back-pressure on a two-deep instance; completions under direct control
    @(negedge clk);
    bp_rst = 1'b0;
    bp_if.req_valid_i = 4'b0001;
    bp_if.req_a_i = {4{32'h3F800000}};
    bp_if.req_b_i = {4{32'h3F800000}};
    bp_hs = 0; bp_pop = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bp_if.req_ready_o[0]) bp_hs++;
      @(negedge clk);
    end
    chk("bp_hs_count", 64'(bp_hs), 64'd2);
    #1;
    chk("bp_stalled", 64'(bp_if.req_ready_o), 64'h0);
    @(negedge clk);
    bp_if.mul_done_i = 1'b1; bp_pop++;
    #1;
    chk("bp_ready_at_pop", 64'(bp_if.req_ready_o), 64'h0);
    @(negedge clk);
    bp_if.mul_done_i = 1'b0;
    #1;
    chk("bp_regrant", 64'(bp_if.req_ready_o), 64'h1);
    chk("bp_rsp", 64'(bp_if.rsp_valid_o), 64'h1);
    if (bp_if.req_ready_o[0]) bp_hs++;
    @(negedge clk);
    #1;
    chk("bp_full_again", 64'(bp_if.req_ready_o), 64'h0);
    chk("bp_busy", 64'(bp_if.busy_o), 64'd1);
    chk("bp_max_outstanding", 64'(bp_hs - bp_pop <= 2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
